// File: rtl/serial_serdes_pkg.sv
`default_nettype none
// ============================================================================
//  serial_serdes_pkg : shared width constants and helpers for the serial SerDes
//  Revision 1.0
// ============================================================================
package serial_serdes_pkg;

    localparam int SERIAL_WORD_W = 32;

    function automatic int serdes_beats(input int w);
        return SERIAL_WORD_W / w;
    endfunction

    // A one-beat word still needs a 1-bit counter so the port widths stay legal.
    function automatic int serdes_cnt_w(input int w);
        int beats;
        beats = SERIAL_WORD_W / w;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_narrow_deser.sv
`default_nettype none
// ============================================================================
//  serial_narrow_deser : reassembles LSB-first W-bit beats into 32-bit words
//  Revision 1.0
// ============================================================================
module serial_narrow_deser
    import serial_serdes_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     narrow_in_valid,
    output logic                     narrow_in_ready,
    input  logic [W-1:0]             narrow_in_bits,
    output logic                     wide_out_valid,
    input  logic                     wide_out_ready,
    output logic [SERIAL_WORD_W-1:0] wide_out_bits
);

    localparam int                 BEATS     = serdes_beats(W);
    localparam int                 CNT_W     = serdes_cnt_w(W);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

    if ((W < 1) || (W > SERIAL_WORD_W) || ((SERIAL_WORD_W % W) != 0)) begin : g_bad_width
        $error("serial_narrow_deser: W must evenly divide 32");
    end

    logic [CNT_W-1:0]         rx_cnt_q, rx_cnt_d;
    logic [SERIAL_WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic                     rx_full_q, rx_full_d;
    logic [SERIAL_WORD_W-1:0] shift_in;
    logic                     beat_fire;
    logic                     word_fire;

    // New beats enter at the top so the first beat ends up in the low bits.
    if (BEATS == 1) begin : g_single_beat
        assign shift_in = narrow_in_bits;
    end else begin : g_multi_beat
        assign shift_in = {narrow_in_bits, rx_shift_q[SERIAL_WORD_W-1:W]};
    end

    assign narrow_in_ready = reset && (!rx_full_q || wide_out_ready);
    assign beat_fire       = narrow_in_valid && narrow_in_ready;
    assign word_fire       = rx_full_q && wide_out_ready;
    assign wide_out_valid  = rx_full_q;
    assign wide_out_bits   = rx_shift_q;

    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_full_d  = rx_full_q;
        if (word_fire) begin
            rx_full_d = 1'b0;
        end
        if (beat_fire) begin
            rx_shift_d = shift_in;
            if (rx_cnt_q == LAST_BEAT) begin
                rx_cnt_d  = '0;
                rx_full_d = 1'b1;
            end else begin
                rx_cnt_d  = rx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_cnt_q  <= '0;
            rx_full_q <= 1'b0;
        end else begin
            rx_cnt_q  <= rx_cnt_d;
            rx_full_q <= rx_full_d;
        end
        rx_shift_q <= rx_shift_d;
    end

endmodule
`default_nettype wire

// File: rtl/serial_narrow_serdes.sv
`default_nettype none
// ============================================================================
//  serial_narrow_serdes : 32-bit host word <-> W-bit off-chip link converter
//  Revision 1.0
// ============================================================================
module serial_narrow_serdes
    import serial_serdes_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wide_in_valid,
    output logic                     wide_in_ready,
    input  logic [SERIAL_WORD_W-1:0] wide_in_bits,
    output logic                     narrow_out_valid,
    input  logic                     narrow_out_ready,
    output logic [W-1:0]             narrow_out_bits,
    input  logic                     narrow_in_valid,
    output logic                     narrow_in_ready,
    input  logic [W-1:0]             narrow_in_bits,
    output logic                     wide_out_valid,
    input  logic                     wide_out_ready,
    output logic [SERIAL_WORD_W-1:0] wide_out_bits
);

    localparam int                 BEATS     = serdes_beats(W);
    localparam int                 CNT_W     = serdes_cnt_w(W);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

    if ((W < 1) || (W > SERIAL_WORD_W) || ((SERIAL_WORD_W % W) != 0)) begin : g_bad_width
        $error("serial_narrow_serdes: W must evenly divide 32");
    end

    logic                     tx_busy_q, tx_busy_d;
    logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d;
    logic [SERIAL_WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic                     tx_beat_fire;
    logic                     tx_word_fire;

    // A new word may enter on the same edge the last beat leaves: no bubble.
    assign wide_in_ready    = reset && (!tx_busy_q || (narrow_out_ready && (tx_cnt_q == LAST_BEAT)));
    assign tx_word_fire     = wide_in_valid && wide_in_ready;
    assign tx_beat_fire     = tx_busy_q && narrow_out_ready;
    assign narrow_out_valid = tx_busy_q;
    assign narrow_out_bits  = tx_shift_q[W-1:0];

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        if (tx_beat_fire) begin
            tx_shift_d = tx_shift_q >> W;
            if (tx_cnt_q == LAST_BEAT) begin
                tx_busy_d = 1'b0;
                tx_cnt_d  = '0;
            end else begin
                tx_cnt_d  = tx_cnt_q + 1'b1;
            end
        end
        if (tx_word_fire) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_shift_d = wide_in_bits;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
        end else begin
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
        end
        tx_shift_q <= tx_shift_d;
    end

    serial_narrow_deser #(
        .W (W)
    ) u_deser (
        .clock           (clock),
        .reset           (reset),
        .narrow_in_valid (narrow_in_valid),
        .narrow_in_ready (narrow_in_ready),
        .narrow_in_bits  (narrow_in_bits),
        .wide_out_valid  (wide_out_valid),
        .wide_out_ready  (wide_out_ready),
        .wide_out_bits   (wide_out_bits)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_narrow_serdes.sv
`default_nettype none
// ============================================================================
//  tb_serial_narrow_serdes : checks W=4 and W=32 instances against a queue model
//  Revision 1.0
// ============================================================================
module tb_serial_narrow_serdes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  w_in_v, n_out_r, n_in_v, w_out_r;
    logic [31:0] wib [2];
    logic [31:0] nib [2];
    wire  [1:0]  w_in_r, n_out_v, n_in_r, w_out_v;
    wire  [3:0]  nob0;
    wire  [31:0] nob1, wob0, wob1;

    serial_narrow_serdes #(.W(4)) u_dut4 (
        .clock            (clk),
        .reset            (rst_n),
        .wide_in_valid    (w_in_v[0]),
        .wide_in_ready    (w_in_r[0]),
        .wide_in_bits     (wib[0]),
        .narrow_out_valid (n_out_v[0]),
        .narrow_out_ready (n_out_r[0]),
        .narrow_out_bits  (nob0),
        .narrow_in_valid  (n_in_v[0]),
        .narrow_in_ready  (n_in_r[0]),
        .narrow_in_bits   (nib[0][3:0]),
        .wide_out_valid   (w_out_v[0]),
        .wide_out_ready   (w_out_r[0]),
        .wide_out_bits    (wob0)
    );

    serial_narrow_serdes #(.W(32)) u_dut32 (
        .clock            (clk),
        .reset            (rst_n),
        .wide_in_valid    (w_in_v[1]),
        .wide_in_ready    (w_in_r[1]),
        .wide_in_bits     (wib[1]),
        .narrow_out_valid (n_out_v[1]),
        .narrow_out_ready (n_out_r[1]),
        .narrow_out_bits  (nob1),
        .narrow_in_valid  (n_in_v[1]),
        .narrow_in_ready  (n_in_r[1]),
        .narrow_in_bits   (nib[1]),
        .wide_out_valid   (w_out_v[1]),
        .wide_out_ready   (w_out_r[1]),
        .wide_out_bits    (wob1)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: expected outgoing beats, collected incoming beats, held word.
    logic [31:0] txq [$];
    logic [31:0] rq  [$];
    bit          have_word = 1'b0;
    logic [31:0] held;

    function automatic logic [31:0] obs_nob(input int k);
        return (k == 0) ? {28'b0, nob0} : nob1;
    endfunction

    function automatic logic [31:0] obs_wob(input int k);
        return (k == 0) ? wob0 : wob1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance k: check outputs, then advance the model.
    task automatic cyc(input int k, output bit wf, output bit rbf);
        int          w;
        int          nb;
        logic [31:0] mask;
        logic [31:0] acc;
        logic        exp_wir, exp_nir;
        bit          bf, rwf;
        w    = (k == 0) ? 4 : 32;
        nb   = 32 / w;
        mask = (k == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
        #1;
        exp_wir = rst_n && (txq.size() == 0 || (n_out_r[k] && txq.size() == 1));
        exp_nir = rst_n && (!have_word || w_out_r[k]);
        chk1("wide_in_ready", w_in_r[k], exp_wir);
        chk1("narrow_out_valid", n_out_v[k], txq.size() != 0);
        if (txq.size() != 0) chk("narrow_out_bits", obs_nob(k), txq[0]);
        chk1("narrow_in_ready", n_in_r[k], exp_nir);
        chk1("wide_out_valid", w_out_v[k], have_word);
        if (have_word) chk("wide_out_bits", obs_wob(k), held);
        bf  = (txq.size() != 0) && n_out_r[k];
        wf  = w_in_v[k] && exp_wir;
        rwf = have_word && w_out_r[k];
        rbf = n_in_v[k] && exp_nir;
        @(posedge clk);
        if (!rst_n) begin
            txq.delete();
            rq.delete();
            have_word = 1'b0;
            wf  = 1'b0;
            rbf = 1'b0;
        end else begin
            if (bf) void'(txq.pop_front());
            if (wf) for (int j = 0; j < nb; j++) txq.push_back((wib[k] >> (j * w)) & mask);
            if (rwf) have_word = 1'b0;
            if (rbf) begin
                rq.push_back(nib[k] & mask);
                if (rq.size() == nb) begin
                    acc = 32'h0;
                    foreach (rq[j]) acc = acc | (rq[j] << (j * w));
                    held      = acc;
                    have_word = 1'b1;
                    rq.delete();
                end
            end
        end
        #1;
    endtask

    task automatic rand_run(input int k, input int n, input int pv, input int pr);
        bit          wf, rbf;
        logic [31:0] mask;
        mask = (k == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            if (!w_in_v[k] && ($urandom_range(99) < pv)) begin
                w_in_v[k] = 1'b1;
                wib[k]    = $urandom;
            end
            if (!n_in_v[k] && ($urandom_range(99) < pv)) begin
                n_in_v[k] = 1'b1;
                nib[k]    = $urandom & mask;
            end
            n_out_r[k] = ($urandom_range(99) < pr);
            w_out_r[k] = ($urandom_range(99) < pr);
            cyc(k, wf, rbf);
            if (wf)  w_in_v[k] = 1'b0;
            if (rbf) n_in_v[k] = 1'b0;
        end
        w_in_v[k]  = 1'b0;
        n_in_v[k]  = 1'b0;
        n_out_r[k] = 1'b1;
        w_out_r[k] = 1'b1;
        for (int i = 0; i < 12; i++) cyc(k, wf, rbf);
    endtask

    initial begin
        bit          wf, rbf;
        logic [31:0] beats;
        rst_n   = 1'b0;
        w_in_v  = 2'b00;
        n_in_v  = 2'b00;
        n_out_r = 2'b11;
        w_out_r = 2'b11;
        wib     = '{default: 32'h0};
        nib     = '{default: 32'h0};
        repeat (2) @(posedge clk);
        #1;
        cyc(0, wf, rbf);
        cyc(0, wf, rbf);
        rst_n = 1'b1;
        cyc(0, wf, rbf);

        // TX single word: beats 8..1
        wib[0] = 32'h1234_5678;
        w_in_v[0] = 1'b1;
        cyc(0, wf, rbf);
        w_in_v[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("tx_single_beat", obs_nob(0), 32'(8 - i));
            cyc(0, wf, rbf);
        end

        // TX back-to-back words held valid
        wib[0] = 32'hA5A5_A5A5;
        w_in_v[0] = 1'b1;
        for (int i = 0; i < 20 && !wf; i++) cyc(0, wf, rbf);
        wib[0] = 32'h0000_000F;
        cyc(0, wf, rbf);
        for (int i = 0; i < 20 && !wf; i++) cyc(0, wf, rbf);
        chk1("b2b_second_accepted", wf, 1'b1);
        w_in_v[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) chk("b2b_second_beat", obs_nob(0), (i == 0) ? 32'hF : 32'h0);
            cyc(0, wf, rbf);
        end

        // RX assembly: beats 1..8
        n_in_v[0] = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            nib[0] = 32'(b);
            cyc(0, wf, rbf);
        end
        n_in_v[0] = 1'b0;
        chk1("rx_word_valid", w_out_v[0], 1'b1);
        chk("rx_word_bits", wob0, 32'h8765_4321);
        cyc(0, wf, rbf);

        // RX back-pressure, then word and next beat on the same edge
        w_out_r[0] = 1'b0;
        n_in_v[0]  = 1'b1;
        for (int b = 8; b <= 15; b++) begin
            nib[0] = 32'(b);
            cyc(0, wf, rbf);
        end
        nib[0] = 32'h1;
        for (int i = 0; i < 3; i++) begin
            chk1("rx_bp_ready", n_in_r[0], 1'b0);
            chk("rx_bp_word", wob0, 32'hFEDC_BA98);
            cyc(0, wf, rbf);
        end
        w_out_r[0] = 1'b1;
        cyc(0, wf, rbf);
        chk1("rx_bp_same_edge_beat", rbf, 1'b1);
        for (int b = 2; b <= 8; b++) begin
            nib[0] = 32'(b);
            cyc(0, wf, rbf);
        end
        n_in_v[0] = 1'b0;
        chk("rx_bp_next_word", wob0, 32'h8765_4321);
        cyc(0, wf, rbf);

        rand_run(0, 400, 70, 70);

        // Reset mid-word: 3 TX beats and 5 RX beats in flight
        wib[0] = 32'hCAFE_BABE;
        w_in_v[0] = 1'b1;
        cyc(0, wf, rbf);
        w_in_v[0] = 1'b0;
        n_in_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_out_r[0] = (i < 3);
            nib[0] = 32'(i + 3);
            cyc(0, wf, rbf);
        end
        n_in_v[0] = 1'b0;
        rst_n = 1'b0;
        cyc(0, wf, rbf);
        cyc(0, wf, rbf);
        chk1("rst_tx_valid", n_out_v[0], 1'b0);
        chk1("rst_rx_valid", w_out_v[0], 1'b0);
        rst_n = 1'b1;
        n_out_r[0] = 1'b1;
        wib[0] = 32'h0BAD_F00D;
        w_in_v[0] = 1'b1;
        cyc(0, wf, rbf);
        w_in_v[0] = 1'b0;
        beats = 32'h0BAD_F00D;
        n_in_v[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nib[0] = beats & 32'hF;
            beats  = beats >> 4;
            cyc(0, wf, rbf);
        end
        n_in_v[0] = 1'b0;
        chk("rst_fresh_word", wob0, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) cyc(0, wf, rbf);

        // W=32 instance: continuous traffic, then random
        rst_n = 1'b0;
        cyc(1, wf, rbf);
        rst_n = 1'b1;
        rand_run(1, 60, 100, 100);
        rand_run(1, 300, 60, 70);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
